// File: rtl/modexp_pkg.sv
// modexp_pkg: shared definitions for the modular-exponentiation sequencer.
// Holds the FSM state encoding (also shown on the debug LEDs), the operand-select
// codes understood by the multiplier datapath, and a helper to classify states.
package modexp_pkg;

    // State encoding is 4 bits so it can be driven straight onto the debug LEDs.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PRECONV  = 4'd1,
        S_INIT     = 4'd2,
        S_SQUARE   = 4'd3,
        S_MULT     = 4'd4,
        S_NEXT     = 4'd5,
        S_POSTCONV = 4'd6,
        S_DONE     = 4'd7
    } state_t;

    // A operand select codes.
    localparam logic [1:0] SEL_ACC  = 2'd0;
    localparam logic [1:0] SEL_XT   = 2'd1;
    localparam logic [1:0] SEL_BASE = 2'd2;

    // B operand select codes (ACC and XT share the A codes).
    localparam logic [1:0] SEL_R2   = 2'd2;
    localparam logic [1:0] SEL_ONE  = 2'd3;

    // True for every state that owns exactly one multiply on the core.
    function automatic logic isMulState(input state_t s);
        return (s == S_PRECONV) || (s == S_SQUARE) ||
               (s == S_MULT)    || (s == S_POSTCONV);
    endfunction

endpackage

// File: rtl/mm_handshake.sv
// mm_handshake: start/done handshake towards the Montgomery multiplier core.
// Fires a one-cycle start pulse whenever the sequencer enters a multiply state,
// remembers that a multiply is outstanding, and only lets a done pulse through
// while one is. Done pulses in the start cycle or with nothing outstanding are dropped.
module mm_handshake
    import modexp_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_state,
    input  logic       i_mm_done,
    output logic       o_mm_start,
    output logic       o_done_q
);

    state_t w_state;
    state_t r_prevState;
    logic   r_outstanding;
    logic   w_entered;

    assign w_state   = state_t'(i_state);
    assign w_entered = isMulState(w_state) && (w_state != r_prevState);

    // Reset masks the pulses in the same cycle so the datapath never sees a stray write.
    assign o_mm_start = w_entered && !i_reset;
    assign o_done_q   = i_mm_done && r_outstanding && !i_reset;

    // Track the previous state for entry detection and the outstanding-multiply flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prevState   <= S_IDLE;
            r_outstanding <= 1'b0;
        end else begin
            r_prevState <= w_state;
            if (w_entered) begin
                r_outstanding <= 1'b1;
            end else if (o_done_q) begin
                r_outstanding <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/modexp_sequencer.sv
// modexp_sequencer: control FSM for left-to-right binary modular exponentiation
// on a Montgomery multiplier. Holds no operand data; it steers the A/B operand
// muxes, launches one multiply at a time and says which register takes the result.
// Optional feature macro: MODEXP_PRECONV_EN -- when defined, the sequencer first
// converts BASE into the Montgomery domain (XT <- BASE*R2); otherwise XT must
// already hold the converted base before start.
module modexp_sequencer
    import modexp_pkg::*;
#(
    parameter int EXP_BITS = 1024,
    parameter int LEN_W    = $clog2(EXP_BITS + 1)
)
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [EXP_BITS-1:0] i_exp,
    input  logic [LEN_W-1:0]    i_exp_len,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_mm_start,
    input  logic                i_mm_done,
    output logic [1:0]          o_mm_a_sel,
    output logic [1:0]          o_mm_b_sel,
    output logic                o_acc_init,
    output logic                o_acc_we,
    output logic                o_xt_we,
    output logic [3:0]          o_leds
);

    state_t              r_state;
    logic [EXP_BITS-1:0] r_expShift;
    logic [LEN_W-1:0]    r_bitIdx;
    logic                r_lenZero;
    logic [1:0]          r_aSel;
    logic [1:0]          r_bSel;
    logic                r_accInit;
    logic                r_done;

    logic                w_mmDoneQ;
    logic                w_mmStart;
    logic [LEN_W-1:0]    w_alignShift;

    // The exponent is left-aligned at capture so the bit under test is always the MSB.
    assign w_alignShift = LEN_W'(EXP_BITS) - i_exp_len;

    mm_handshake u_handshake (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_state    (r_state),
        .i_mm_done  (i_mm_done),
        .o_mm_start (w_mmStart),
        .o_done_q   (w_mmDoneQ)
    );

    assign o_mm_start = w_mmStart;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_mm_a_sel = r_aSel;
    assign o_mm_b_sel = r_bSel;
    assign o_acc_init = r_accInit;
    assign o_leds     = r_state;

    assign o_acc_we = w_mmDoneQ &&
                      ((r_state == S_SQUARE) || (r_state == S_MULT) || (r_state == S_POSTCONV));
`ifdef MODEXP_PRECONV_EN
    assign o_xt_we  = w_mmDoneQ && (r_state == S_PRECONV);
`else
    assign o_xt_we  = 1'b0;
`endif

    // Main sequencing FSM: state, exponent shift register and registered controls.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_expShift <= '0;
            r_bitIdx   <= '0;
            r_lenZero  <= 1'b0;
            r_aSel     <= SEL_ACC;
            r_bSel     <= SEL_ACC;
            r_accInit  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_accInit <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_expShift <= i_exp << w_alignShift;
                        r_bitIdx   <= i_exp_len - 1'b1;
                        r_lenZero  <= (i_exp_len == '0);
`ifdef MODEXP_PRECONV_EN
                        r_state    <= S_PRECONV;
                        r_aSel     <= SEL_BASE;
                        r_bSel     <= SEL_R2;
`else
                        r_state    <= S_INIT;
                        r_accInit  <= 1'b1;
`endif
                    end
                end
`ifdef MODEXP_PRECONV_EN
                S_PRECONV: begin
                    if (w_mmDoneQ) begin
                        r_state   <= S_INIT;
                        r_accInit <= 1'b1;
                        r_aSel    <= SEL_ACC;
                        r_bSel    <= SEL_ACC;
                    end
                end
`endif
                S_INIT: begin
                    r_aSel <= SEL_ACC;
                    if (r_lenZero) begin
                        r_state <= S_POSTCONV;
                        r_bSel  <= SEL_ONE;
                    end else begin
                        r_state <= S_SQUARE;
                        r_bSel  <= SEL_ACC;
                    end
                end
                S_SQUARE: begin
                    if (w_mmDoneQ) begin
                        if (r_expShift[EXP_BITS-1]) begin
                            r_state <= S_MULT;
                            r_bSel  <= SEL_XT;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end
                end
                S_MULT: begin
                    if (w_mmDoneQ) begin
                        r_state <= S_NEXT;
                        r_bSel  <= SEL_ACC;
                    end
                end
                S_NEXT: begin
                    r_aSel <= SEL_ACC;
                    if (r_bitIdx == '0) begin
                        r_state <= S_POSTCONV;
                        r_bSel  <= SEL_ONE;
                    end else begin
                        r_state    <= S_SQUARE;
                        r_bSel     <= SEL_ACC;
                        r_bitIdx   <= r_bitIdx - 1'b1;
                        r_expShift <= {r_expShift[EXP_BITS-2:0], 1'b0};
                    end
                end
                S_POSTCONV: begin
                    if (w_mmDoneQ) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_aSel  <= SEL_ACC;
                        r_bSel  <= SEL_ACC;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_aSel  <= SEL_ACC;
                    r_bSel  <= SEL_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_sequencer.sv
// tb_modexp_sequencer: directed bench for modexp_sequencer with a latency-3 stub
// multiplier. Expected op orders, counts and latencies are worked out by hand for
// both builds (MODEXP_PRECONV_EN defined or not).
module tb_modexp_sequencer;
    import modexp_pkg::*;

    localparam int EXP_BITS = 1024;
    localparam int LEN_W    = $clog2(EXP_BITS + 1);
`ifdef MODEXP_PRECONV_EN
    localparam int PRE = 1;
`else
    localparam int PRE = 0;
`endif
    // Cycle offset (from the start cycle) of the INIT state.
    localparam int INIT_OFF = 1 + 4 * PRE;

    // Op codes logged as {a_sel, b_sel}.
    localparam int OP_PRE  = 10;
    localparam int OP_SQ   = 0;
    localparam int OP_MUL  = 1;
    localparam int OP_POST = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [EXP_BITS-1:0] expIn = '0;
    logic [LEN_W-1:0]    expLen = '0;
    logic                spuriousDone = 1'b0;
    logic [2:0]          stubPipe = '0;
    logic                mmDone;

    logic       busy, done, mmStart, accInit, accWe, xtWe;
    logic [1:0] aSel, bSel;
    logic [3:0] leds;

    int nAsserts = 0;
    int nFails   = 0;
    int cyc      = 0;
    int startCyc = 0;

    int startCount   = 0;
    int accWeCount   = 0;
    int xtWeCount    = 0;
    int accInitCount = 0;
    int doneCount    = 0;
    int sel2Cycles   = 0;
    int lastDoneCyc  = 0;
    int opLog [4096];

    modexp_sequencer #(.EXP_BITS(EXP_BITS)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_exp      (expIn),
        .i_exp_len  (expLen),
        .o_busy     (busy),
        .o_done     (done),
        .o_mm_start (mmStart),
        .i_mm_done  (mmDone),
        .o_mm_a_sel (aSel),
        .o_mm_b_sel (bSel),
        .o_acc_init (accInit),
        .o_acc_we   (accWe),
        .o_xt_we    (xtWe),
        .o_leds     (leds)
    );

    always #5 clk = ~clk;

    // Cycle counter; value during a cycle is the index of that cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // Stub multiplier: done arrives three cycles after start; reset with the sequencer.
    always @(posedge clk) begin
        if (reset) stubPipe <= '0;
        else       stubPipe <= {stubPipe[1:0], mmStart};
    end
    assign mmDone = stubPipe[2] | spuriousDone;

    // Monitor sampling DUT outputs mid-cycle and accumulating event counts.
    always @(negedge clk) begin
        if (mmStart) begin
            if (startCount < 4096) opLog[startCount] = int'({aSel, bSel});
            startCount = startCount + 1;
        end
        if (accWe)   accWeCount   = accWeCount + 1;
        if (xtWe)    xtWeCount    = xtWeCount + 1;
        if (accInit) accInitCount = accInitCount + 1;
        if (aSel == 2'd2 || bSel == 2'd2) sel2Cycles = sel2Cycles + 1;
        if (done) begin
            doneCount   = doneCount + 1;
            lastDoneCyc = cyc;
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [13:0] packOutputs();
        return {busy, done, mmStart, aSel, bSel, accInit, accWe, xtWe, leds};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [EXP_BITS-1:0] e, input logic [LEN_W-1:0] len);
        @(posedge clk); #1;
        expIn    = e;
        expLen   = len;
        start    = 1'b1;
        startCyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitUntilCycle(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitDone(input int base, input int budget, input string tag);
        int n = 0;
        while (doneCount == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput({tag, "_done_seen"}, 32'(doneCount != base), 1);
    endtask

    // Full exp=0b1011, len=4 run; optionally with busy-start and stray done pulses.
    task automatic run1011(input string tag, input bit inject);
        int expOps [9] = '{OP_PRE, OP_SQ, OP_MUL, OP_SQ, OP_SQ, OP_MUL, OP_SQ, OP_MUL, OP_POST};
        int s0 = startCount;
        int a0 = accWeCount;
        int x0 = xtWeCount;
        int i0 = accInitCount;
        int d0 = doneCount;
        int g0 = sel2Cycles;
        applyStimulus(EXP_BITS'(4'b1011), LEN_W'(4));
        if (inject) spuriousDone = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_busy"}, 32'(busy), 1);
        checkOutput({tag, "_leds_first"}, 32'(leds), (PRE != 0) ? 32'(S_PRECONV) : 32'(S_INIT));
        @(posedge clk); #1;
        spuriousDone = 1'b0;
        if (inject) begin
            waitUntilCycle(startCyc + INIT_OFF + 9);
            spuriousDone = 1'b1;
            @(negedge clk);
            checkOutput({tag, "_leds_next"}, 32'(leds), 32'(S_NEXT));
            @(posedge clk); #1;
            spuriousDone = 1'b0;
            waitUntilCycle(startCyc + 20);
            expIn  = '1;
            expLen = LEN_W'(3);
            start  = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        waitDone(d0, 200, tag);
        checkOutput({tag, "_latency"}, 32'(lastDoneCyc - startCyc), 32'(38 + 4 * PRE));
        checkOutput({tag, "_mm_starts"}, 32'(startCount - s0), 32'(8 + PRE));
        for (int k = 0; k < 8 + PRE; k++) begin
            checkOutput($sformatf("%s_op%0d", tag, k), 32'(opLog[s0 + k]), 32'(expOps[k + 1 - PRE]));
        end
        checkOutput({tag, "_acc_we"}, 32'(accWeCount - a0), 8);
        checkOutput({tag, "_xt_we"}, 32'(xtWeCount - x0), 32'(PRE));
        checkOutput({tag, "_acc_init"}, 32'(accInitCount - i0), 1);
        checkOutput({tag, "_sel2_cycles"}, 32'(sel2Cycles - g0), 32'(4 * PRE));
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_done_count"}, 32'(doneCount - d0), 1);
        checkOutput({tag, "_idle_after"}, 32'(packOutputs()), 0);
    endtask

    initial begin
        int s0, a0, x0, i0, d0, g0, sR;
        $display("[TB] modexp_sequencer bench, PRE=%0d", PRE);

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_outputs", 32'(packOutputs()), 0);
        checkOutput("reset_leds", 32'(leds), 32'(S_IDLE));

        // Basic 0b1011 sequence
        run1011("b1011", 1'b0);

        // Zero-length exponent: INIT, POSTCONV, DONE
        s0 = startCount; a0 = accWeCount; i0 = accInitCount; d0 = doneCount;
        applyStimulus(EXP_BITS'(4'b1011), LEN_W'(0));
        waitDone(d0, 100, "len0");
        checkOutput("len0_latency", 32'(lastDoneCyc - startCyc), 32'(6 + 4 * PRE));
        checkOutput("len0_mm_starts", 32'(startCount - s0), 32'(1 + PRE));
        checkOutput("len0_last_op", 32'(opLog[startCount - 1]), OP_POST);
        checkOutput("len0_acc_init", 32'(accInitCount - i0), 1);
        checkOutput("len0_acc_we", 32'(accWeCount - a0), 1);
        repeat (3) @(posedge clk);

        // Start while busy plus stray mm_done in INIT/NEXT
        run1011("busy_inject", 1'b1);

        // Reset in the cycle SQUARE's done arrives
        d0 = doneCount;
        applyStimulus(EXP_BITS'(4'b1011), LEN_W'(4));
        waitUntilCycle(startCyc + INIT_OFF + 4);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_leds_in_square", 32'(leds), 32'(S_SQUARE));
        checkOutput("rst_acc_we_masked", 32'(accWe), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        sR = startCount;
        @(negedge clk);
        checkOutput("rst_outputs_next", 32'(packOutputs()), 0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_no_done", 32'(doneCount - d0), 0);
        checkOutput("rst_no_restart", 32'(startCount - sR), 0);
        run1011("after_rst", 1'b0);

        // All-ones exponent at full length
        s0 = startCount; a0 = accWeCount; x0 = xtWeCount; d0 = doneCount; g0 = sel2Cycles;
        applyStimulus('1, LEN_W'(EXP_BITS));
        waitDone(d0, 12000, "full");
        checkOutput("full_latency", 32'(lastDoneCyc - startCyc), 32'(9222 + 4 * PRE));
        checkOutput("full_mm_starts", 32'(startCount - s0), 32'(2049 + PRE));
        checkOutput("full_acc_we", 32'(accWeCount - a0), 2049);
        checkOutput("full_xt_we", 32'(xtWeCount - x0), 32'(PRE));
        checkOutput("full_sel2_cycles", 32'(sel2Cycles - g0), 32'(4 * PRE));
        checkOutput("full_last_op", 32'(opLog[startCount - 1]), OP_POST);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/modexp_sequencer.md
# modexp_sequencer

Control FSM that sequences a Montgomery multiplier core through left-to-right binary modular exponentiation. It sits between the ARM command wrapper and the multiplier datapath, and holds no operand data. It steers operand-select muxes, issues one multiply at a time over a start/done handshake, and tells the datapath which register captures each result. Together with the wrapper and the multiplier core it performs a full RSA exponentiation from one `start`.

## Interface
- `EXP_BITS`, 1024: maximum exponent width.
- `LEN_W`, `$clog2(EXP_BITS+1)`: width of `exp_len`.
- `clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: begin exponentiation; sampled only in IDLE.
- `exp`  in  EXP_BITS: exponent; captured on accepted `start`.
- `exp_len`  in  LEN_W: number of exponent bits to process (bits `exp_len-1`..0); captured with `exp`.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse when the result is in ACC.
- `mm_start`  out  1: one-cycle pulse launching a multiply.
- `mm_done`  in  1: multiplier result valid, one-cycle pulse.
- `mm_a_sel`  out  2: A operand select. 0=ACC, 1=XT, 2=BASE.
- `mm_b_sel`  out  2: B operand select. 0=ACC, 1=XT, 2=R2, 3=ONE.
- `acc_init`  out  1: datapath loads ACC ← R mod N.
- `acc_we`  out  1: datapath captures the multiplier result into ACC.
- `xt_we`  out  1: datapath captures the multiplier result into XT.
- `leds`  out  4: current state encoding, for debug.

## Operation
- States: IDLE, PRECONV, INIT, SQUARE, MULT, NEXT, POSTCONV, DONE.
- IDLE
  - On `start`, latch `exp` into a shift register and set `bit_idx ← exp_len-1`.
  - Go to PRECONV, or to INIT when PRECONV is compiled out.
- PRECONV: XT ← MontMul(BASE, R2). Selects A=2, B=2; result goes through `xt_we`. Then INIT.
- INIT: one cycle with `acc_init`=1.
  - `exp_len`=0: go to POSTCONV.
  - Otherwise: go to SQUARE.
- SQUARE: ACC ← MontMul(ACC, ACC). Selects A=0, B=0; result through `acc_we`.
  - Exponent bit `exp[bit_idx]`=1: go to MULT.
  - Exponent bit = 0: go to NEXT.
- MULT: ACC ← MontMul(ACC, XT). Selects A=0, B=1; result through `acc_we`. Then NEXT.
- NEXT: one cycle.
  - `bit_idx`=0: go to POSTCONV.
  - Otherwise: decrement `bit_idx` and go to SQUARE.
- POSTCONV: ACC ← MontMul(ACC, ONE). Selects A=0, B=3; result through `acc_we`. Then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Multiply count per run: `exp_len` squares + popcount(`exp[exp_len-1:0]`) mults + 1 postconv (+1 preconv).
- `exp_len` > EXP_BITS is out of contract.

## Timing
- Reset values: all outputs 0; state IDLE; `leds`=IDLE encoding.
- `start` asserted in cycle t (IDLE): state changes in cycle t+1. `start` while busy is ignored.
- Each multiply state (PRECONV, SQUARE, MULT, POSTCONV):
  - `mm_start`=1 only in the first cycle of the state.
  - Selects are held stable for the whole state.
- `mm_done` handling:
  - Sampled only from the cycle after `mm_start` onward.
  - `mm_done` in cycle t asserts `acc_we`/`xt_we` combinationally in cycle t, and the next state is taken at t+1.
  - `mm_done` with no multiply outstanding (IDLE, INIT, NEXT, DONE, or the `mm_start` cycle) is ignored.
- Core latency L cycles (start to done): each multiply state lasts L+1 cycles; INIT and NEXT last 1 cycle each.
- `reset` mid-operation: IDLE on the next edge; `mm_start`/`*_we` deassert immediately; no `done`. The multiplier must be reset in the same cycle.
- `start` coincident with `reset`: reset wins.

## Configuration
- `MODEXP_PRECONV_EN` defined:
  - PRECONV state exists.
  - BASE is a normal-domain value and is converted into XT by the sequencer.
- Not defined:
  - PRECONV is removed; IDLE goes directly to INIT.
  - XT must already hold the Montgomery-domain base before `start`.
  - `mm_a_sel`=2 and `mm_b_sel`=2 never occur; `xt_we` is tied 0.

## Structure
- Shared package `modexp_pkg`: state enum and encodings (4 bits, matching `leds`); A/B select constants (SEL_ACC, SEL_XT, SEL_BASE, SEL_R2, SEL_ONE).
- One sub-module, `mm_handshake`: issues the `mm_start` pulse on state entry, tracks the outstanding multiply, and qualifies `mm_done`.
- The FSM and the exponent shift register live in the top.

## Test plan
Bench uses a stub multiplier with latency L=3.
- Reset mid-SQUARE: all outputs 0 the next cycle; no `done`; a following `start` runs a full, normal sequence.
- `exp`=0b1011, `exp_len`=4, PRECONV on:
  - Op order PRE, SQ, MUL, SQ, SQ, MUL, SQ, MUL, POST (9 `mm_start` pulses).
  - `done` at cycle 1+9·4+1+4 = 42 after `start`.
- `exp_len`=0: INIT, POSTCONV, DONE; exactly one (PRECONV off) or two (PRECONV on) `mm_start` pulses; `acc_init` pulsed once.
- `start` pulsed while busy, plus spurious `mm_done` during INIT/NEXT: no restart, no extra `acc_we`, sequence unchanged.
- PRECONV off, `exp`=all ones, `exp_len`=1024: 2048 loop multiplies + 1 post; `xt_we` never high; select value 2 never seen.
- End-to-end with the real core, N = 3233, e = 17, base = 65: ACC converts to 2790.
